csa_pipe_adder: RTL

- Parametrised, 2-stage pipelined carry-skip adder/subtractor with valid/ready handshakes on both sides.
- Operands are split into BLOCK-bit ripple-carry groups, with a skip mux per group.
- Stage 1 computes the lower half and registers the mid carry; stage 2 computes the upper half.
- Successor to the fixed 8-bit combinational adder. Adds width/block generics, subtract mode, carry-in, signed saturation and status flags.

---
 rtl/csa_pipe_adder_if.sv | 23 ++
 rtl/csa_pipe_adder.sv | 81 ++++++++
 2 files changed

// File: rtl/csa_pipe_adder_if.sv
// csa_pipe_adder_if: operand/result valid-ready bus of the pipelined carry-skip adder
interface csa_pipe_adder_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;
   modport master (
      output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: 2-stage carry-skip add/sub, lower half in stage 1, upper half plus flags/saturation in stage 2
module csa_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4,
   parameter int SAT   = 0
) (
   input logic clk,
   input logic rst,
   csa_pipe_adder_if.slave bus
);
   localparam int H = WIDTH / 2;
   function automatic logic [H:0] skip_add(input logic [H-1:0] a, input logic [H-1:0] b, input logic c);
      logic [H-1:0] s;
      logic gc, rc, p;
      s  = '0;
      gc = c;
      for (int g = 0; g < H / BLOCK; g++) begin
         rc = gc;
         p  = 1'b1;
         for (int i = 0; i < BLOCK; i++) begin
            s[g*BLOCK+i] = a[g*BLOCK+i] ^ b[g*BLOCK+i] ^ rc;
            p  = p & (a[g*BLOCK+i] ^ b[g*BLOCK+i]);
            rc = (a[g*BLOCK+i] & b[g*BLOCK+i]) | (rc & (a[g*BLOCK+i] ^ b[g*BLOCK+i]));
         end
         gc = p ? gc : rc;
      end
      return {gc, s};
   endfunction
   logic             s1_valid, s2_valid, s1_en, s2_en, s1_c, c0, ovf;
   logic [H-1:0]     s1_lo, s1_ah, s1_bh;
   logic [H:0]       lo, hi;
   logic [WIDTH-1:0] beff, sum, res;
   always_comb begin
      s2_en = !s2_valid || bus.out_ready;
      s1_en = !s1_valid || s2_en;
      beff  = bus.in_sub ? ~bus.in_b : bus.in_b;
      c0    = bus.in_sub | bus.in_cin;
      lo    = skip_add(bus.in_a[H-1:0], beff[H-1:0], c0);
      hi    = skip_add(s1_ah, s1_bh, s1_c);
      sum   = {hi[H-1:0], s1_lo};
      // carry into the MSB is recovered as a ^ b ^ sum at that bit
      ovf   = s1_ah[H-1] ^ s1_bh[H-1] ^ hi[H-1] ^ hi[H];
      res   = (SAT != 0 && ovf) ? (s1_ah[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : sum;
   end
   assign bus.in_ready  = s1_en & ~rst;
   assign bus.out_valid = s2_valid;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_c     <= 1'b0;
         s1_ah    <= '0;
         s1_bh    <= '0;
      end else if (s1_en) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_lo <= lo[H-1:0];
            s1_c  <= lo[H];
            s1_ah <= bus.in_a[WIDTH-1:H];
            s1_bh <= beff[WIDTH-1:H];
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid     <= 1'b0;
         bus.out_sum  <= '0;
         bus.out_cout <= 1'b0;
         bus.out_ovf  <= 1'b0;
         bus.out_zero <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_sum  <= res;
            bus.out_cout <= hi[H];
            bus.out_ovf  <= ovf;
            bus.out_zero <= res == '0;
         end
      end
   end
endmodule
